// File: rtl/seg_bcd_seq.sv
// Binary-to-BCD sequencer for a 5-digit 7-segment display.
// A start in idle captures a 16-bit product and converts it with 16 serial
// double-dabble steps. The five digits are then presented one per cycle
// (ones first) with done high, so downstream per-digit registers can latch them.
module seg_bcd_seq #(
  parameter int unsigned BLANK_LZ = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] product,
  output logic [6:0]  seg_code,
  output logic [2:0]  seg_mux_sel,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StEmit
  } state_e;

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegZero  = 7'b0000001;
  localparam int unsigned NumDigits = 5;

  state_e      state_q;
  logic [15:0] bin_q;
  logic [19:0] bcd_q;
  logic [3:0]  iter_q;
  logic [2:0]  emit_q;

  logic [19:0] bcd_adj;
  logic [35:0] shifted;
  logic [19:0] bcd_step;
  logic [15:0] bin_step;

  logic [3:0]  digit;
  logic        lead_zero;
  logic [6:0]  digit_seg;

  // Active-low segment pattern for one BCD digit; anything above 9 is blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  // One double-dabble step: bias every nibble >= 5 by 3, then shift {bcd, bin} left by one.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shifted  = {bcd_adj, bin_q} << 1;
    bcd_step = shifted[35:16];
    bin_step = shifted[15:0];
  end

  // Select the nibble being emitted and work out whether it is a leading zero.
  always_comb begin
    digit     = 4'd0;
    lead_zero = 1'b0;
    case (emit_q)
      3'd0: digit = bcd_q[3:0];
      3'd1: begin
        digit     = bcd_q[7:4];
        lead_zero = (bcd_q[19:4] == 16'd0);
      end
      3'd2: begin
        digit     = bcd_q[11:8];
        lead_zero = (bcd_q[19:8] == 12'd0);
      end
      3'd3: begin
        digit     = bcd_q[15:12];
        lead_zero = (bcd_q[19:12] == 8'd0);
      end
      3'd4: begin
        digit     = bcd_q[19:16];
        lead_zero = (bcd_q[19:16] == 4'd0);
      end
      default: ;
    endcase
    // The ones digit never sets lead_zero, so a zero product still shows "0".
    digit_seg = ((BLANK_LZ != 0) && lead_zero) ? SegBlank : seg_decode(digit);
  end

  // Sequencer: accept, convert for 16 cycles, emit 5 digits, then one cleanup cycle back to idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      bin_q       <= 16'd0;
      bcd_q       <= 20'd0;
      iter_q      <= 4'd0;
      emit_q      <= 3'd0;
      seg_code    <= SegZero;
      seg_mux_sel <= 3'd0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done        <= 1'b0;
          seg_mux_sel <= 3'd0;
          if (start) begin
            bin_q   <= product;
            bcd_q   <= 20'd0;
            iter_q  <= 4'd0;
            emit_q  <= 3'd0;
            busy    <= 1'b1;
            state_q <= StConv;
          end else begin
            busy <= 1'b0;
          end
        end

        StConv: begin
          bcd_q  <= bcd_step;
          bin_q  <= bin_step;
          iter_q <= iter_q + 4'd1;
          if (iter_q == 4'd15) begin
            state_q <= StEmit;
          end
        end

        StEmit: begin
          if (emit_q < 3'(NumDigits)) begin
            done        <= 1'b1;
            seg_mux_sel <= emit_q;
            seg_code    <= digit_seg;
            emit_q      <= emit_q + 3'd1;
          end else begin
            // seg_code intentionally keeps the last digit shown.
            done        <= 1'b0;
            busy        <= 1'b0;
            seg_mux_sel <= 3'd0;
            emit_q      <= 3'd0;
            state_q     <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_bcd_seq.sv
// Bench for seg_bcd_seq: two instances (leading-zero blanking off and on) share
// stimulus. Expected digits come from decimal arithmetic on the product and
// are queued at issue time; a negedge monitor pops and compares each done cycle.
module tb_seg_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] product;
  logic [6:0]  seg  [2];
  logic [2:0]  sel  [2];
  logic        done [2];
  logic        busy [2];

  int edge_cnt = 0;
  int passed   = 0;
  int total    = 0;

  logic [9:0] expq [2][$];
  int         accq [2][$];
  logic       prev_done [2];
  int         run_len   [2];
  int         mon_a;
  logic [9:0] mon_e;

  seg_bcd_seq #(.BLANK_LZ(0)) u_dut0 (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .product     (product),
    .seg_code    (seg[0]),
    .seg_mux_sel (sel[0]),
    .done        (done[0]),
    .busy        (busy[0])
  );

  seg_bcd_seq #(.BLANK_LZ(1)) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .product     (product),
    .seg_code    (seg[1]),
    .seg_mux_sel (sel[1]),
    .done        (done[1]),
    .busy        (busy[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference: decimal digits by division; dut1 blanks digits above the value's magnitude.
  task automatic push(input logic [15:0] p, input int acc);
    int         pw;
    logic [6:0] s;
    for (int d = 0; d < 2; d++) begin
      accq[d].push_back(acc);
      pw = 1;
      for (int k = 0; k < 5; k++) begin
        if (d == 1 && k > 0 && int'(p) < pw) s = 7'b1111111;
        else s = seg_of((int'(p) / pw) % 10);
        expq[d].push_back({k[2:0], s});
        pw = pw * 10;
      end
    end
  endtask

  task automatic issue(input logic [15:0] p, input bit keep);
    start   = 1'b1;
    product = p;
    @(posedge clk); #1;
    start   = 1'b0;
    product = 16'($urandom);
    if (keep) push(p, edge_cnt);
    for (int d = 0; d < 2; d++) check($sformatf("dut%0d busy after accept", d), busy[d], 1);
  endtask

  task automatic noise(input int n);
    for (int i = 0; i < n; i++) begin
      start   = 1'($urandom);
      product = 16'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy[0] !== 1'b0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait for idle", busy[0], 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s dut%0d seg", tag, d), seg[d], 7'b0000001);
      check($sformatf("%s dut%0d sel", tag, d), sel[d], 0);
      check($sformatf("%s dut%0d done", tag, d), done[d], 0);
      check($sformatf("%s dut%0d busy", tag, d), busy[d], 0);
    end
  endtask

  // Monitor: every done cycle must match the next queued digit; bursts are 5 long
  // and start 17 edges after their accepting edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (done[d]) begin
        if (!prev_done[d]) begin
          run_len[d] = 0;
          if (accq[d].size() == 0) check($sformatf("dut%0d unexpected burst", d), done[d], 0);
          else begin
            mon_a = accq[d].pop_front();
            check($sformatf("dut%0d first done latency", d), edge_cnt - mon_a, 17);
          end
        end
        run_len[d]++;
        check($sformatf("dut%0d busy during done", d), busy[d], 1);
        if (expq[d].size() == 0) check($sformatf("dut%0d unexpected digit", d), done[d], 0);
        else begin
          mon_e = expq[d].pop_front();
          check($sformatf("dut%0d mux sel", d), sel[d], mon_e[9:7]);
          check($sformatf("dut%0d seg code sel%0d", d, mon_e[9:7]), seg[d], mon_e[6:0]);
        end
      end else if (prev_done[d]) begin
        check($sformatf("dut%0d burst length", d), run_len[d], 5);
      end
      if (sel[d] > 3'd4) check($sformatf("dut%0d sel range", d), sel[d], 4);
      prev_done[d] = done[d];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         a;
    logic [15:0] p;
    rst     = 1'b0;
    start   = 1'b0;
    product = 16'd0;
    for (int d = 0; d < 2; d++) begin
      prev_done[d] = 1'b0;
      run_len[d]   = 0;
    end
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Directed values, including the first edge after reset release.
    issue(16'd65025, 1); wait_idle();
    issue(16'd144, 1);   wait_idle();
    issue(16'd0, 1);     wait_idle();
    issue(16'd65535, 1); wait_idle();
    issue(16'd10000, 1); wait_idle();
    issue(16'd100, 1);   wait_idle();

    // A second start during conversion is ignored.
    issue(16'd65025, 1);
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; product = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    // Random products with input noise while busy and random idle gaps (0 = back-to-back).
    for (int i = 0; i < 25; i++) begin
      case ($urandom % 4)
        0:       p = 16'($urandom);
        1:       p = 16'($urandom_range(0, 9));
        2:       p = 16'($urandom_range(0, 999));
        default: p = 16'($urandom_range(9990, 10010));
      endcase
      issue(p, 1);
      noise(int'($urandom_range(0, 18)));
      wait_idle();
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Reset mid-conversion aborts without a burst.
    issue(16'd300, 0);
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (30) begin @(posedge clk); #1; end
    check("idle after abort", busy[0], 0);
    issue(16'd9, 1); wait_idle();

    // Start held high: accepts every 23 edges (22-edge operation plus one idle cycle).
    start = 1'b1; product = 16'd255;
    @(posedge clk); #1;
    a = edge_cnt;
    push(16'd255, a);
    push(16'd255, a + 23);
    push(16'd255, a + 46);
    repeat (46) begin @(posedge clk); #1; end
    start = 1'b0;
    wait_idle();

    repeat (5) begin @(posedge clk); #1; end
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d leftover digits", d), expq[d].size(), 0);
      check($sformatf("dut%0d leftover bursts", d), accq[d].size(), 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seg_bcd_seq.md
SEG_BCD_SEQ -- requirements
Module: seg_bcd_seq

Interface
REQ-001 SHALL have parameter BLANK_LZ, default 0; 1 = blank leading-zero digits (ones digit never blanked).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to convert and emit product; sampled only in IDLE.
REQ-005 SHALL have port product  input  16  unsigned multiplier result; captured on the edge that accepts start.
REQ-006 SHALL have port seg_code  output  7  registered 7-segment code, bit6=a to bit0=g, active-low.
REQ-007 SHALL have port seg_mux_sel  output  3  registered digit index: 0=ones, 1=tens, 2=hundreds, 3=thousands, 4=ten-thousands.
REQ-008 SHALL have port done  output  1  registered; high while seg_code/seg_mux_sel carry a valid digit for downstream per-digit registers.
REQ-009 SHALL have port busy  output  1  registered; high from acceptance of start until the last emitted digit.

Function
REQ-010 SHALL implement FSM states IDLE, CONV, EMIT; all outputs driven from registers.
REQ-011 IDLE: start=1 at a rising edge SHALL capture product, clear 20-bit BCD accumulator, set iteration count 0, set busy=1, go to CONV.
REQ-012 CONV: each cycle SHALL perform one double-dabble step (each 4-bit BCD nibble >=5 gets +3, then shift {bcd, bin} left 1); exactly 16 steps, then go to EMIT.
REQ-013 EMIT: SHALL hold 5 cycles with done=1, seg_mux_sel stepping 0,1,2,3,4 one per cycle, seg_code = decode of the indexed BCD nibble.
REQ-014 First done=1 cycle SHALL start after the 17th rising edge following the start-accepting edge; done high exactly 5 consecutive cycles.
REQ-015 After the seg_mux_sel=4 cycle SHALL return to IDLE with done=0, busy=0, seg_mux_sel=0; seg_code holds its last value.
REQ-016 Decode SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; blank=1111111.
REQ-017 BLANK_LZ=1: digit k>0 SHALL emit 1111111 when it and all higher digits are zero; embedded zeros SHALL show 0000001.
REQ-018 start while busy=1 SHALL be ignored; product changes while busy SHALL not affect the result.
REQ-019 start=1 in the first IDLE cycle after EMIT SHALL be accepted (back-to-back, 1 idle cycle minimum).
REQ-020 All 16-bit inputs (0..65535) SHALL convert correctly; no overflow case exists for 5 digits.
REQ-021 done SHALL never be high outside EMIT; seg_mux_sel SHALL never exceed 4.

Reset
REQ-022 rst=0 SHALL immediately force state IDLE, seg_code=0000001, seg_mux_sel=0, done=0, busy=0, accumulator and counters 0.
REQ-023 rst asserted during CONV or EMIT SHALL abort the operation; no further done pulses until a new start after release.
REQ-024 First start SHALL be accepted on the first rising edge with rst=1.

Verification
REQ-025 BLANK_LZ=0, product=65025, start 1 cycle -> after 17 edges done=1 for 5 cycles: sel0 0100100, sel1 0010010, sel2 0000001, sel3 0100100, sel4 0100000; then busy=0.
REQ-026 BLANK_LZ=1, product=144 -> sel0 1001100, sel1 1001100, sel2 1001111, sel3 1111111, sel4 1111111; product=0 -> sel0 0000001, sel1..4 1111111.
REQ-027 product=65025 accepted, start pulsed again with product=1 at cycle 5 of CONV -> only one 5-cycle done burst, digits of 65025.
REQ-028 rst low for 1 cycle at CONV step 8 -> outputs 0000001/0/0/0 immediately, no done burst; next start with product=9 -> sel0 0000100, sel1..4 0000001 (BLANK_LZ=0).
REQ-029 start held high continuously, product=255 -> repeated bursts 2,5,5 (1 idle cycle between bursts), each burst exactly 5 cycles, sel 0..4 in order.
